// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Optional write-first forwarding is enabled by defining WRITE_BYPASS_EN.
package reg_file_mp_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int REG_ZERO     = 0;

  // A strobe only counts when it targets a real (non-zero) register.
  function automatic logic write_hits(input logic en, input int unsigned waddr,
                                      input int unsigned addr);
    return en && (waddr == addr) && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy flags: reserve sets, late (MDU) write clears, reserve wins.
module reg_file_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int  NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_set_en,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr_en,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_busy
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == REG_ZERO) begin : g_zero
        assign o_busy[gi] = 1'b0;
      end else begin : g_flop
        logic r_busy;
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            r_busy <= 1'b0;
          end else if (write_hits(i_set_en, int'(i_set_addr), gi)) begin
            r_busy <= 1'b1;
          end else if (write_hits(i_clr_en, int'(i_clr_addr), gi)) begin
            r_busy <= 1'b0;
          end
        end
        assign o_busy[gi] = r_busy;
      end
    end
  endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, WB + late MDU writes, busy scoreboard.
// Define WRITE_BYPASS_EN for write-first forwarding of same-cycle writes onto read ports.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  NUM_RD   = DEF_NUM_RD,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_RD*ADDR_W-1:0] RD_ADDRESS,
  output logic [NUM_RD*DATA_W-1:0] RD_DATA,
  output logic [NUM_RD-1:0]        RD_BUSY,
  input  logic                     WRITE_ENABLE0,
  input  logic [ADDR_W-1:0]        WRITE_ADDRESS0,
  input  logic [DATA_W-1:0]        WRITE_DATA0,
  input  logic                     WRITE_ENABLE1,
  input  logic [ADDR_W-1:0]        WRITE_ADDRESS1,
  input  logic [DATA_W-1:0]        WRITE_DATA1,
  input  logic                     RESERVE_ENABLE,
  input  logic [ADDR_W-1:0]        RESERVE_ADDRESS
);

  logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;
  logic [NUM_REGS-1:0]             w_busy;

  reg_file_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_set_en   (RESERVE_ENABLE),
    .i_set_addr (RESERVE_ADDRESS),
    .i_clr_en   (WRITE_ENABLE1),
    .i_clr_addr (WRITE_ADDRESS1),
    .o_busy     (w_busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == REG_ZERO) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] r_data;
        // Port 0 (WB) has priority over the late MDU port on an address collision.
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) begin
            r_data <= '0;
          end else if (write_hits(WRITE_ENABLE0, int'(WRITE_ADDRESS0), gi)) begin
            r_data <= WRITE_DATA0;
          end else if (write_hits(WRITE_ENABLE1, int'(WRITE_ADDRESS1), gi)) begin
            r_data <= WRITE_DATA1;
          end
        end
        assign w_regs[gi] = r_data;
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_data;
      logic              w_busy_bit;

      assign w_ra = RD_ADDRESS[gi*ADDR_W +: ADDR_W];

      always_comb begin
        w_data     = w_regs[w_ra];
        w_busy_bit = w_busy[w_ra];
`ifdef WRITE_BYPASS_EN
        if (write_hits(WRITE_ENABLE0, int'(WRITE_ADDRESS0), int'(w_ra))) begin
          w_data = WRITE_DATA0;
        end else if (write_hits(WRITE_ENABLE1, int'(WRITE_ADDRESS1), int'(w_ra))) begin
          w_data = WRITE_DATA1;
        end
        // A completing MDU write releases the register unless a newer producer reserves it.
        if (write_hits(WRITE_ENABLE1, int'(WRITE_ADDRESS1), int'(w_ra)) &&
            !write_hits(RESERVE_ENABLE, int'(RESERVE_ADDRESS), int'(w_ra))) begin
          w_busy_bit = 1'b0;
        end
`endif
        if (RESET) begin
          w_data     = '0;
          w_busy_bit = 1'b0;
        end
      end

      assign RD_DATA[gi*DATA_W +: DATA_W] = w_data;
      assign RD_BUSY[gi]                  = w_busy_bit;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: expected reads are queued as stimulus is driven, then popped and compared.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NRD = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NRD*AW-1:0] RD_ADDRESS;
  logic [NRD*DW-1:0] RD_DATA;
  logic [NRD-1:0]    RD_BUSY;
  logic              WRITE_ENABLE0, WRITE_ENABLE1, RESERVE_ENABLE;
  logic [AW-1:0]     WRITE_ADDRESS0, WRITE_ADDRESS1, RESERVE_ADDRESS;
  logic [DW-1:0]     WRITE_DATA0, WRITE_DATA1;

  reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .RD_ADDRESS      (RD_ADDRESS),
    .RD_DATA         (RD_DATA),
    .RD_BUSY         (RD_BUSY),
    .WRITE_ENABLE0   (WRITE_ENABLE0),
    .WRITE_ADDRESS0  (WRITE_ADDRESS0),
    .WRITE_DATA0     (WRITE_DATA0),
    .WRITE_ENABLE1   (WRITE_ENABLE1),
    .WRITE_ADDRESS1  (WRITE_ADDRESS1),
    .WRITE_DATA1     (WRITE_DATA1),
    .RESERVE_ENABLE  (RESERVE_ENABLE),
    .RESERVE_ADDRESS (RESERVE_ADDRESS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_reg [NR];
  logic        m_busy[NR];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, req);
    end
  endtask

  // Drive a read address on a port and queue what it should return.
  task automatic push_read(input string tag, input int port, input int addr,
                           input logic [31:0] data, input logic busy);
    exp_t e;
    RD_ADDRESS[port*AW +: AW] = AW'(addr);
    e.tag = tag; e.port = port; e.data = data; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic drain;
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({e.tag, "_data"}, RD_DATA[e.port*DW +: DW], e.data);
      check_eq({e.tag, "_busy"}, 32'(RD_BUSY[e.port]), 32'(e.busy));
      $display("read %-14s port%0d data=%h busy=%0d", e.tag, e.port,
               RD_DATA[e.port*DW +: DW], RD_BUSY[e.port]);
    end
  endtask

  task automatic idle_inputs;
    WRITE_ENABLE0 = 0; WRITE_ADDRESS0 = '0; WRITE_DATA0 = '0;
    WRITE_ENABLE1 = 0; WRITE_ADDRESS1 = '0; WRITE_DATA1 = '0;
    RESERVE_ENABLE = 0; RESERVE_ADDRESS = '0;
  endtask

  // Inputs change on the falling edge; one full cycle later the next falling edge.
  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic model_update(input logic we0, input int wa0, input logic [31:0] wd0,
                              input logic we1, input int wa1, input logic [31:0] wd1,
                              input logic re, input int ra);
    if (we1 && wa1 != 0) begin
      if (!(we0 && wa0 == wa1)) m_reg[wa1] = wd1;
      m_busy[wa1] = 1'b0;
    end
    if (we0 && wa0 != 0) m_reg[wa0] = wd0;
    if (re && ra != 0) m_busy[ra] = 1'b1;
  endtask

  initial begin
    logic we0, we1, re;
    int   wa0, wa1, ra, a0, a1;
    logic [31:0] wd0, wd1;

    RESET = 1'b1;
    RD_ADDRESS = '0;
    idle_inputs();
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end

    // Writes presented during reset must be ignored.
    WRITE_ENABLE0 = 1; WRITE_ADDRESS0 = 5'd9; WRITE_DATA0 = 32'h1234;
    @(negedge CLK);
    @(negedge CLK);
    idle_inputs();
    RESET = 1'b0;

    for (int a = 0; a < NR; a++) begin
      push_read($sformatf("rst_a%0d", a), 0, a, 32'd0, 1'b0);
      push_read($sformatf("rst_b%0d", NR-1-a), 1, NR-1-a, 32'd0, 1'b0);
      drain();
    end

    WRITE_ENABLE0 = 1; WRITE_ADDRESS0 = 5'd1; WRITE_DATA0 = 32'd10;
    tick();
    model_update(1, 1, 32'd10, 0, 0, 0, 0, 0);
    push_read("wr_r1_p0", 0, 1, 32'd10, 1'b0);
    push_read("wr_r1_p1", 1, 1, 32'd10, 1'b0);
    drain();

    WRITE_ENABLE0 = 1; WRITE_ADDRESS0 = 5'd0; WRITE_DATA0 = 32'hDEADBEEF;
    RESERVE_ENABLE = 1; RESERVE_ADDRESS = 5'd0;
    tick();
    push_read("r0_zero", 0, 0, 32'd0, 1'b0);
    drain();

    WRITE_ENABLE0 = 1; WRITE_ADDRESS0 = 5'd5; WRITE_DATA0 = 32'd7;
    WRITE_ENABLE1 = 1; WRITE_ADDRESS1 = 5'd5; WRITE_DATA1 = 32'd9;
    tick();
    model_update(1, 5, 32'd7, 1, 5, 32'd9, 0, 0);
    push_read("coll_r5", 0, 5, 32'd7, 1'b0);
    drain();

    WRITE_ENABLE0 = 1; WRITE_ADDRESS0 = 5'd5; WRITE_DATA0 = 32'd7;
    WRITE_ENABLE1 = 1; WRITE_ADDRESS1 = 5'd6; WRITE_DATA1 = 32'd9;
    tick();
    model_update(1, 5, 32'd7, 1, 6, 32'd9, 0, 0);
    push_read("split_r5", 0, 5, 32'd7, 1'b0);
    push_read("split_r6", 1, 6, 32'd9, 1'b0);
    drain();

    RESERVE_ENABLE = 1; RESERVE_ADDRESS = 5'd3;
    tick();
    model_update(0, 0, 0, 0, 0, 0, 1, 3);
    push_read("rsv_r3", 0, 3, 32'd0, 1'b1);
    drain();

    WRITE_ENABLE1 = 1; WRITE_ADDRESS1 = 5'd3; WRITE_DATA1 = 32'd42;
    tick();
    model_update(0, 0, 0, 1, 3, 32'd42, 0, 0);
    push_read("mdu_r3", 1, 3, 32'd42, 1'b0);
    drain();

    RESERVE_ENABLE = 1; RESERVE_ADDRESS = 5'd4;
    WRITE_ENABLE1 = 1; WRITE_ADDRESS1 = 5'd4; WRITE_DATA1 = 32'd77;
    tick();
    model_update(0, 0, 0, 1, 4, 32'd77, 1, 4);
    push_read("rsv_clr_r4", 0, 4, 32'd77, 1'b1);
    drain();

    RESERVE_ENABLE = 1; RESERVE_ADDRESS = 5'd4;
    tick();
    model_update(0, 0, 0, 0, 0, 0, 1, 4);
    push_read("rsv_again_r4", 1, 4, 32'd77, 1'b1);
    drain();

    // Same-cycle read of reg 8 while it is being written.
    WRITE_ENABLE0 = 1; WRITE_ADDRESS0 = 5'd8; WRITE_DATA0 = 32'h55;
`ifdef WRITE_BYPASS_EN
    push_read("byp_pre_r8", 0, 8, 32'h55, 1'b0);
`else
    push_read("byp_pre_r8", 0, 8, 32'h0, 1'b0);
`endif
    drain();
    tick();
    model_update(1, 8, 32'h55, 0, 0, 0, 0, 0);
    push_read("byp_post_r8", 0, 8, 32'h55, 1'b0);
    drain();

    // MDU write completing on busy reg 4 with no competing reserve.
    WRITE_ENABLE1 = 1; WRITE_ADDRESS1 = 5'd4; WRITE_DATA1 = 32'h66;
`ifdef WRITE_BYPASS_EN
    push_read("byp_pre_r4", 1, 4, 32'h66, 1'b0);
`else
    push_read("byp_pre_r4", 1, 4, 32'd77, 1'b1);
`endif
    drain();
    tick();
    model_update(0, 0, 0, 1, 4, 32'h66, 0, 0);
    push_read("byp_post_r4", 1, 4, 32'h66, 1'b0);
    drain();

    for (int it = 0; it < 40; it++) begin
      we0 = 1'($urandom); wa0 = int'($urandom_range(0, NR-1)); wd0 = $urandom;
      we1 = 1'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : int'($urandom_range(0, NR-1));
      wd1 = $urandom;
      re  = 1'($urandom); ra = ($urandom_range(0, 3) == 0) ? wa1 : int'($urandom_range(0, NR-1));
      WRITE_ENABLE0 = we0; WRITE_ADDRESS0 = AW'(wa0); WRITE_DATA0 = wd0;
      WRITE_ENABLE1 = we1; WRITE_ADDRESS1 = AW'(wa1); WRITE_DATA1 = wd1;
      RESERVE_ENABLE = re; RESERVE_ADDRESS = AW'(ra);
      tick();
      model_update(we0, wa0, wd0, we1, wa1, wd1, re, ra);
      a0 = wa0; a1 = ($urandom_range(0, 1) == 0) ? wa1 : ra;
      push_read($sformatf("rnd%0d_a", it), 0, a0, m_reg[a0], m_busy[a0]);
      push_read($sformatf("rnd%0d_b", it), 1, a1, m_reg[a1], m_busy[a1]);
      drain();
    end

    // Reset landing 2 ns after the edge that commits a write to reg 2.
    RESERVE_ENABLE = 1; RESERVE_ADDRESS = 5'd12;
    tick();
    WRITE_ENABLE0 = 1; WRITE_ADDRESS0 = 5'd2; WRITE_DATA0 = 32'd99;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    push_read("arst_r2", 0, 2, 32'd0, 1'b0);
    push_read("arst_r12", 1, 12, 32'd0, 1'b0);
    drain();
    @(negedge CLK);
    idle_inputs();
    RESET = 1'b0;
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
    for (int a = 0; a < NR; a += 2) begin
      push_read($sformatf("post_rst%0d", a), 0, a, 32'd0, 1'b0);
      push_read($sformatf("post_rst%0d", a+1), 1, a+1, 32'd0, 1'b0);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port successor to the pipeline's 2R/1W register file. Provides NUM_RD combinational read ports and two synchronous write ports: WB stage, plus a late port for multi-cycle MUL/DIV. Adds a per-register busy scoreboard for the decode-stage hazard unit. Sits between ID (reads/reserve) and WB/MDU (writes).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, register count; power of two, >=2
ADDR_W, $clog2(NUM_REGS), address width (derived, not overridable)
NUM_RD, 2, read port count, 1..4

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-high; clears all registers and busy bits
RD_ADDRESS  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
RD_DATA  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
RD_BUSY  out  NUM_RD  port i's register has a pending reservation
WRITE_ENABLE0  in  1  port 0 (WB) write strobe
WRITE_ADDRESS0  in  ADDR_W  port 0 destination
WRITE_DATA0  in  DATA_W  port 0 data
WRITE_ENABLE1  in  1  port 1 (MDU late) write strobe
WRITE_ADDRESS1  in  ADDR_W  port 1 destination
WRITE_DATA1  in  DATA_W  port 1 data
RESERVE_ENABLE  in  1  mark destination busy (long-latency issue)
RESERVE_ADDRESS  in  ADDR_W  register to reserve

Behaviour:
- Reset (async, any time incl. mid-write): all registers = 0, all busy bits = 0; RD_DATA = 0 and RD_BUSY = 0 while RESET high. Writes/reserves during RESET are ignored.
- Read: combinational, zero-cycle latency from RD_ADDRESS to RD_DATA/RD_BUSY.
- Register 0: reads always 0 and never busy. Writes and reserves to address 0 are silently dropped.
- Write: on posedge CLK, if WRITE_ENABLEn and address != 0, reg <= WRITE_DATAn. The new value is visible on reads after that edge.
- Both write ports to the same non-zero address in one cycle: port 0 wins; port 1 data is discarded. Different addresses: both commit.
- Scoreboard: on posedge, RESERVE_ENABLE sets busy[RESERVE_ADDRESS]. A port-1 write clears busy[WRITE_ADDRESS1]. A port-0 write does not touch busy.
- Reserve and port-1 clear of the same address in the same cycle: reserve wins, busy stays 1 (newer in-flight producer).
- Reserve of an already-busy register: busy stays 1, no error.
- No internal FSM beyond per-register data and busy flops. Outputs settle within the same cycle as input changes.

Optional Feature:
WRITE_BYPASS_EN:
- Defined: write-first forwarding. If a read address matches an enabled same-cycle write, RD_DATA returns that write's data combinationally, port 0 taking precedence. RD_BUSY is forced 0 when a port-1 write to that address is present and no same-cycle reserve targets it. Address 0 is never bypassed.
- Undefined: read returns the stored value. Same-cycle write data appears only after the edge.

Decomposition:
- Shared package/macros header: DATA_W and NUM_REGS defaults, the REG_ZERO address constant, and an assert macro for the bench.
- One natural sub-module, reg_file_scoreboard: the NUM_REGS busy bitvector with set/clear priority logic, exposing a busy vector.
- Read muxing and bypass stay in reg_file_mp.

Test Plan:
- Reset then read all ports at addresses 0..31 -> RD_DATA=0, RD_BUSY=0 everywhere.
- WRITE_ENABLE0 to reg 1 with 10, posedge, read reg 1 on ports 0 and 1 -> both 32'd10. Write 0xDEADBEEF to reg 0 -> reg 0 reads 0.
- Same cycle: port0 writes reg 5 with 7, port1 writes reg 5 with 9 -> reg 5 = 7. Repeat with port1 to reg 6 -> reg 5 = 7, reg 6 = 9.
- RESERVE reg 3 -> RD_BUSY=1 next cycle. Port1 write reg 3 = 42 -> busy 0, data 42. Reserve and port1 write to reg 4 together -> busy stays 1.
- With WRITE_BYPASS_EN: port0 writes reg 8 = 0x55 while reading reg 8 before the edge -> RD_DATA=0x55 same cycle. Without the macro -> old value until after the edge.
- Assert RESET 2 ns after a posedge during a pending write to reg 2 = 99 -> reg 2 reads 0 immediately, busy vector all 0.
